// File: rtl/scoreboarded_register_file_pkg.sv
// Shared types and constants for the tag-scoreboarded register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 16;
  localparam int REGFILE_TAG_W    = 3;
  localparam int REGFILE_ZERO_REG = 0;

  typedef logic [REGFILE_TAG_W-1:0] tag_t;

  // Read ports are packed side by side; port p starts at p*width.
  function automatic int portLsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/scoreboarded_register_file_if.sv
// Issue/writeback bus of the scoreboarded register file; master drives, slave is the file.
interface scoreboarded_register_file_if
  import regfile_pkg::*;
#(
  parameter int DATABITWIDTH    = REGFILE_DATA_W,
  parameter int REGADDRBITWIDTH = 4,
  parameter int READPORTS       = 2,
  parameter int TAGBITWIDTH     = REGFILE_TAG_W
);
  logic [READPORTS*REGADDRBITWIDTH-1:0] Read_Address;
  logic [READPORTS-1:0]                 Read_En;
  logic [READPORTS*DATABITWIDTH-1:0]    Read_Data;
  logic                                 Dirty_Set;
  logic [REGADDRBITWIDTH-1:0]           Dirty_Address;
  logic [TAGBITWIDTH-1:0]               Dirty_Tag;
  logic                                 Mem_Write_En;
  logic [REGADDRBITWIDTH-1:0]           Mem_Write_Address;
  logic [TAGBITWIDTH-1:0]               Mem_Write_Tag;
  logic [DATABITWIDTH-1:0]              Mem_Write_Data;
  logic                                 Write_En;
  logic [REGADDRBITWIDTH-1:0]           Write_Address;
  logic [DATABITWIDTH-1:0]              Write_Data;
  logic                                 Mem_Write_Stale;
  logic                                 RegistersSync;
  logic                                 RegisterStallOut;

  modport master (
    output Read_Address, Read_En, Dirty_Set, Dirty_Address, Dirty_Tag,
           Mem_Write_En, Mem_Write_Address, Mem_Write_Tag, Mem_Write_Data,
           Write_En, Write_Address, Write_Data,
    input  Read_Data, Mem_Write_Stale, RegistersSync, RegisterStallOut
  );

  modport slave (
    input  Read_Address, Read_En, Dirty_Set, Dirty_Address, Dirty_Tag,
           Mem_Write_En, Mem_Write_Address, Mem_Write_Tag, Mem_Write_Data,
           Write_En, Write_Address, Write_Data,
    output Read_Data, Mem_Write_Stale, RegistersSync, RegisterStallOut
  );
endinterface

// File: rtl/scoreboarded_register_file_cell.sv
// One scoreboarded register: data, pending-load flag and the tag of the newest load.
module scoreboard_reg_cell
  import regfile_pkg::*;
#(
  parameter int DW = REGFILE_DATA_W,
  parameter int TW = REGFILE_TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          accept_i,
  input  logic [DW-1:0] memData_i,
  input  logic          set_i,
  input  logic [TW-1:0] setTag_i,
  input  logic          write_i,
  input  logic [DW-1:0] writeData_i,
  output logic [DW-1:0] data_o,
  output logic          dirty_o,
  output logic [TW-1:0] tag_o
);

  logic [DW-1:0] data_q, data_d;
  logic          dirty_q, dirty_d;
  logic [TW-1:0] tag_q, tag_d;

  // ALU data beats load data; a new load marking beats the clear from a return.
  always_comb begin
    data_d  = data_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (accept_i) begin
      data_d  = memData_i;
      dirty_d = 1'b0;
    end
    if (write_i) begin
      data_d = writeData_i;
    end
    if (set_i) begin
      dirty_d = 1'b1;
      tag_d   = setTag_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      dirty_q <= 1'b0;
      tag_q   <= '0;
    end else if (clk_en) begin
      data_q  <= data_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

  assign data_o  = data_q;
  assign dirty_o = dirty_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/scoreboarded_register_file.sv
// Multi-port register file with per-register load tags and stall generation.
// Define REGFILE_BYPASS_EN to forward same-cycle ALU/memory writes to the read ports.
module scoreboarded_register_file
  import regfile_pkg::*;
#(
  parameter int DATABITWIDTH    = REGFILE_DATA_W,
  parameter int REGISTERCOUNT   = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int READPORTS       = 2,
  parameter int TAGBITWIDTH     = REGFILE_TAG_W
) (
  input logic clk,
  input logic async_rst,
  input logic clk_en,
  scoreboarded_register_file_if.slave bus
);

  logic [DATABITWIDTH-1:0]           regData [REGISTERCOUNT];
  logic [TAGBITWIDTH-1:0]            regTag  [REGISTERCOUNT];
  logic [REGISTERCOUNT-1:0]          regDirty;
  logic [REGADDRBITWIDTH-1:0]        portAddr  [READPORTS];
  logic [DATABITWIDTH-1:0]           portData  [READPORTS];
  logic                              portDirty [READPORTS];
  logic [READPORTS*DATABITWIDTH-1:0] readData;
  logic                              memAccepted;
  logic                              registerStall;
  logic                              stallBuffer_q, stallBuffer_d;
  logic                              stale_q, stale_d;

  assign regData[0]  = '0;
  assign regTag[0]   = '0;
  assign regDirty[0] = 1'b0;

  // A return retires only if it carries the tag of the newest load to that register.
  assign memAccepted = bus.Mem_Write_En && regDirty[bus.Mem_Write_Address] &&
                       (regTag[bus.Mem_Write_Address] == bus.Mem_Write_Tag);

  for (genvar r = 1; r < REGISTERCOUNT; r++) begin : g_cell
    localparam logic [REGADDRBITWIDTH-1:0] ADDR = REGADDRBITWIDTH'(r);
    scoreboard_reg_cell #(.DW(DATABITWIDTH), .TW(TAGBITWIDTH)) u_cell (
      .clk        (clk),
      .rst        (async_rst),
      .clk_en     (clk_en),
      .accept_i   (memAccepted && (bus.Mem_Write_Address == ADDR)),
      .memData_i  (bus.Mem_Write_Data),
      .set_i      (bus.Dirty_Set && (bus.Dirty_Address == ADDR)),
      .setTag_i   (bus.Dirty_Tag),
      .write_i    (bus.Write_En && (bus.Write_Address == ADDR)),
      .writeData_i(bus.Write_Data),
      .data_o     (regData[r]),
      .dirty_o    (regDirty[r]),
      .tag_o      (regTag[r])
    );
  end

  always_comb begin
    registerStall = 1'b0;
    readData      = '0;
    for (int p = 0; p < READPORTS; p++) begin
      portAddr[p]  = bus.Read_Address[portLsb(p, REGADDRBITWIDTH) +: REGADDRBITWIDTH];
      portData[p]  = regData[portAddr[p]];
      portDirty[p] = regDirty[portAddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (bus.Write_En && (bus.Write_Address == portAddr[p]) &&
          (portAddr[p] != REGADDRBITWIDTH'(REGFILE_ZERO_REG))) begin
        portData[p] = bus.Write_Data;
      end else if (memAccepted && (bus.Mem_Write_Address == portAddr[p])) begin
        portData[p] = bus.Mem_Write_Data;
      end
      if (memAccepted && (bus.Mem_Write_Address == portAddr[p]) &&
          !(bus.Dirty_Set && (bus.Dirty_Address == portAddr[p]))) begin
        portDirty[p] = 1'b0;
      end
`endif
      readData[portLsb(p, DATABITWIDTH) +: DATABITWIDTH] = portData[p];
      registerStall = registerStall | (bus.Read_En[p] & portDirty[p]);
    end
  end

  // The buffer only re-samples while stalling or on a memory return, stretching the stall.
  always_comb begin
    stale_d       = bus.Mem_Write_En && !memAccepted;
    stallBuffer_d = stallBuffer_q;
    if (registerStall || bus.Mem_Write_En) begin
      stallBuffer_d = registerStall;
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      stallBuffer_q <= 1'b0;
      stale_q       <= 1'b0;
    end else if (clk_en) begin
      stallBuffer_q <= stallBuffer_d;
      stale_q       <= stale_d;
    end
  end

  assign bus.Read_Data        = readData;
  assign bus.Mem_Write_Stale  = stale_q;
  assign bus.RegistersSync    = ~|regDirty;
  assign bus.RegisterStallOut = registerStall | stallBuffer_q;

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Scoreboard bench for scoreboarded_register_file; expectations honour REGFILE_BYPASS_EN.
module tb_scoreboarded_register_file;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum {K_SYNC, K_STALL, K_STALE, K_RD0, K_RD1} checkKind_e;

  logic clk = 1'b0;
  logic async_rst;
  logic clk_en;

  scoreboarded_register_file_if #(
    .DATABITWIDTH(16), .REGADDRBITWIDTH(4), .READPORTS(2), .TAGBITWIDTH(3)
  ) bus ();

  scoreboarded_register_file #(
    .DATABITWIDTH(16), .REGISTERCOUNT(16), .REGADDRBITWIDTH(4),
    .READPORTS(2), .TAGBITWIDTH(3)
  ) dut (
    .clk      (clk),
    .async_rst(async_rst),
    .clk_en   (clk_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  string       nameQ[$];
  checkKind_e  kindQ[$];
  logic [15:0] expQ[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [15:0] sampleOutput(input checkKind_e k);
    case (k)
      K_SYNC:  return {15'd0, bus.RegistersSync};
      K_STALL: return {15'd0, bus.RegisterStallOut};
      K_STALE: return {15'd0, bus.Mem_Write_Stale};
      K_RD0:   return bus.Read_Data[15:0];
      default: return bus.Read_Data[31:16];
    endcase
  endfunction

  task automatic checkOutput(input string name, input checkKind_e k, input logic [15:0] e);
    nameQ.push_back(name);
    kindQ.push_back(k);
    expQ.push_back(e);
  endtask

  task automatic clearInputs();
    bus.Read_Address      = '0;
    bus.Read_En           = '0;
    bus.Dirty_Set         = 1'b0;
    bus.Dirty_Address     = '0;
    bus.Dirty_Tag         = '0;
    bus.Mem_Write_En      = 1'b0;
    bus.Mem_Write_Address = '0;
    bus.Mem_Write_Tag     = '0;
    bus.Mem_Write_Data    = '0;
    bus.Write_En          = 1'b0;
    bus.Write_Address     = '0;
    bus.Write_Data        = '0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic setDirty(input logic [3:0] a, input tag_t t);
    bus.Dirty_Set = 1'b1; bus.Dirty_Address = a; bus.Dirty_Tag = t;
  endtask

  task automatic memReturn(input logic [3:0] a, input tag_t t, input logic [15:0] d);
    bus.Mem_Write_En = 1'b1; bus.Mem_Write_Address = a;
    bus.Mem_Write_Tag = t; bus.Mem_Write_Data = d;
  endtask

  task automatic aluWrite(input logic [3:0] a, input logic [15:0] d);
    bus.Write_En = 1'b1; bus.Write_Address = a; bus.Write_Data = d;
  endtask

  task automatic readPort(input int p, input logic [3:0] a);
    bus.Read_En[p] = 1'b1;
    bus.Read_Address[p*4 +: 4] = a;
  endtask

  // Monitor: drains everything queued for this cycle at the falling edge.
  always @(negedge clk) begin
    string       n;
    checkKind_e  k;
    logic [15:0] e, a;
    while (kindQ.size() > 0) begin
      n = nameQ.pop_front();
      k = kindQ.pop_front();
      e = expQ.pop_front();
      a = sampleOutput(k);
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", n, a, e);
      end
    end
  end

  initial begin
    async_rst = 1'b1;
    clk_en    = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);

    applyStimulus(); async_rst = 1'b0;
    checkOutput("rst_sync", K_SYNC, 16'd1);
    checkOutput("rst_stall", K_STALL, 16'd0);
    checkOutput("rst_stale", K_STALE, 16'd0);
    checkOutput("rst_rd0", K_RD0, 16'h0000);

    // Load to r5 tag 2, stall while pending, then accepted return.
    applyStimulus(); setDirty(4'd5, 3'd2); readPort(0, 4'd5);
    checkOutput("set5_sync_before", K_SYNC, 16'd1);
    checkOutput("set5_stall_before", K_STALL, 16'd0);
    applyStimulus(); readPort(0, 4'd5);
    checkOutput("r5_pending_sync", K_SYNC, 16'd0);
    checkOutput("r5_pending_stall", K_STALL, 16'd1);
    applyStimulus(); memReturn(4'd5, 3'd2, 16'hBEEF); readPort(0, 4'd5);
    checkOutput("r5_return_stall", K_STALL, 16'd1);
    checkOutput("r5_return_rd0", K_RD0, BYPASS ? 16'hBEEF : 16'h0000);
    applyStimulus(); readPort(0, 4'd5);
    checkOutput("r5_after_rd0", K_RD0, 16'hBEEF);
    checkOutput("r5_after_sync", K_SYNC, 16'd1);
    checkOutput("r5_after_stale", K_STALE, 16'd0);
    checkOutput("r5_after_stall_buf", K_STALL, BYPASS ? 16'd0 : 16'd1);
    applyStimulus(); memReturn(4'd0, 3'd0, 16'h0000);
    checkOutput("r0_return_stall", K_STALL, BYPASS ? 16'd0 : 16'd1);
    applyStimulus();
    checkOutput("stall_cleared", K_STALL, 16'd0);
    checkOutput("r0_return_stale", K_STALE, 16'd1);
    applyStimulus();
    checkOutput("stale_one_pulse", K_STALE, 16'd0);

    // Two loads to r5; the older tag is stale.
    applyStimulus(); setDirty(4'd5, 3'd1);
    applyStimulus(); setDirty(4'd5, 3'd4);
    applyStimulus(); memReturn(4'd5, 3'd1, 16'h1111);
    checkOutput("r5_old_ret_stale_pre", K_STALE, 16'd0);
    checkOutput("r5_old_ret_sync", K_SYNC, 16'd0);
    applyStimulus(); readPort(1, 4'd5);
    checkOutput("r5_old_ret_stale", K_STALE, 16'd1);
    checkOutput("r5_still_dirty", K_SYNC, 16'd0);
    checkOutput("r5_old_ret_rd1", K_RD1, 16'hBEEF);
    checkOutput("r5_old_ret_stall", K_STALL, 16'd1);
    applyStimulus(); memReturn(4'd5, 3'd4, 16'h2222);
    checkOutput("r5_new_ret_stale", K_STALE, 16'd0);
    checkOutput("r5_new_ret_stall_buf", K_STALL, 16'd1);
    applyStimulus(); readPort(1, 4'd5);
    checkOutput("r5_new_rd1", K_RD1, 16'h2222);
    checkOutput("r5_new_sync", K_SYNC, 16'd1);
    checkOutput("r5_new_stall", K_STALL, 16'd0);
    checkOutput("r5_new_stale", K_STALE, 16'd0);

    // Set and accepted return on r7 in the same cycle.
    applyStimulus(); setDirty(4'd7, 3'd3);
    applyStimulus(); setDirty(4'd7, 3'd6); memReturn(4'd7, 3'd3, 16'h7777);
    checkOutput("r7_both_sync", K_SYNC, 16'd0);
    applyStimulus(); readPort(0, 4'd7);
    checkOutput("r7_both_rd0", K_RD0, 16'h7777);
    checkOutput("r7_both_dirty", K_SYNC, 16'd0);
    checkOutput("r7_both_stall", K_STALL, 16'd1);
    checkOutput("r7_both_stale", K_STALE, 16'd0);
    applyStimulus(); memReturn(4'd7, 3'd3, 16'h9999);
    checkOutput("r7_oldtag_stall_buf", K_STALL, 16'd1);
    applyStimulus(); memReturn(4'd7, 3'd6, 16'h6666);
    checkOutput("r7_oldtag_stale", K_STALE, 16'd1);
    checkOutput("r7_oldtag_stall", K_STALL, 16'd0);
    applyStimulus(); readPort(0, 4'd7);
    checkOutput("r7_tag6_rd0", K_RD0, 16'h6666);
    checkOutput("r7_tag6_sync", K_SYNC, 16'd1);
    checkOutput("r7_tag6_stale", K_STALE, 16'd0);
    checkOutput("r7_tag6_stall", K_STALL, 16'd0);

    // ALU write beats an accepted return to the same register.
    applyStimulus(); setDirty(4'd9, 3'd5);
    applyStimulus(); memReturn(4'd9, 3'd5, 16'hAAAA); aluWrite(4'd9, 16'h5555);
    applyStimulus(); readPort(1, 4'd9);
    checkOutput("r9_alu_wins_rd1", K_RD1, 16'h5555);
    checkOutput("r9_alu_wins_sync", K_SYNC, 16'd1);

    // Register 0 ignores writes and dirty marking.
    applyStimulus(); aluWrite(4'd0, 16'h1234); setDirty(4'd0, 3'd1); readPort(0, 4'd0);
    checkOutput("r0_write_rd0", K_RD0, 16'h0000);
    checkOutput("r0_write_sync", K_SYNC, 16'd1);
    applyStimulus(); readPort(0, 4'd0);
    checkOutput("r0_after_rd0", K_RD0, 16'h0000);
    checkOutput("r0_after_sync", K_SYNC, 16'd1);
    checkOutput("r0_after_stall", K_STALL, 16'd0);

    // ALU write-to-read forwarding on port 1.
    applyStimulus(); aluWrite(4'd2, 16'h0011);
    applyStimulus(); aluWrite(4'd2, 16'h00AA); readPort(1, 4'd2);
    checkOutput("r2_bypass_rd1", K_RD1, BYPASS ? 16'h00AA : 16'h0011);
    applyStimulus(); readPort(1, 4'd2);
    checkOutput("r2_stored_rd1", K_RD1, 16'h00AA);

    // clk_en low freezes everything.
    applyStimulus(); clk_en = 1'b0;
    setDirty(4'd3, 3'd2); aluWrite(4'd4, 16'h4444); memReturn(4'd0, 3'd0, 16'h0000);
    applyStimulus(); clk_en = 1'b1; readPort(0, 4'd4);
    checkOutput("clken_rd0", K_RD0, 16'h0000);
    checkOutput("clken_sync", K_SYNC, 16'd1);
    checkOutput("clken_stale", K_STALE, 16'd0);

    // Asynchronous reset in the middle of a pending load.
    applyStimulus(); setDirty(4'd3, 3'd1);
    applyStimulus(); memReturn(4'd0, 3'd0, 16'h0000);
    applyStimulus(); memReturn(4'd0, 3'd0, 16'h0000);
    checkOutput("pre_rst_sync", K_SYNC, 16'd0);
    checkOutput("pre_rst_stale", K_STALE, 16'd1);
    applyStimulus(); async_rst = 1'b1; readPort(0, 4'd7);
    checkOutput("mid_rst_sync", K_SYNC, 16'd1);
    checkOutput("mid_rst_stale", K_STALE, 16'd0);
    checkOutput("mid_rst_rd0", K_RD0, 16'h0000);
    checkOutput("mid_rst_stall", K_STALL, 16'd0);
    applyStimulus();
    applyStimulus(); async_rst = 1'b0; memReturn(4'd3, 3'd1, 16'h3333);
    applyStimulus(); readPort(0, 4'd3);
    checkOutput("post_rst_stale", K_STALE, 16'd1);
    checkOutput("post_rst_sync", K_SYNC, 16'd1);
    checkOutput("post_rst_rd0", K_RD0, 16'h0000);

    applyStimulus();
    @(negedge clk);
    #1;
    checks++;
    if (kindQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", kindQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
